// File: rtl/sc_pkg.sv
// Shared types for the stochastic stream sequencer.
// Op codes, FSM states and the bitstream combine function.
package sc_pkg;

   localparam int SC_PROB_W = 8;

   typedef enum logic [1:0] {
      SC_OP_AND    = 2'b00,
      SC_OP_OR     = 2'b01,
      SC_OP_XOR    = 2'b10,
      SC_OP_PASS_A = 2'b11
   } sc_op_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_SEED,
      SEQ_RUN,
      SEQ_DONE
   } sc_seq_state_t;

   function automatic logic sc_combine(sc_op_t op, logic a, logic b);
      logic c;
      c = 1'b0;
      unique case (op)
         SC_OP_AND:    c = a & b;
         SC_OP_OR:     c = a | b;
         SC_OP_XOR:    c = a ^ b;
         SC_OP_PASS_A: c = a;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Cycle counter and ones accumulator for one stochastic run.
// wrap_o flags the last counted cycle of the run.
module sc_ones_counter #(
   parameter int unsigned LEN_LOG2 = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic              bit_i,
   output logic [LEN_LOG2:0] ones_o,
   output logic              wrap_o
);

   logic [LEN_LOG2-1:0] cnt_q, cnt_d;
   logic [LEN_LOG2:0]   ones_q, ones_d;

   always_comb begin
      cnt_d  = cnt_q;
      ones_d = ones_q;
      if (clr_i) begin
         cnt_d  = '0;
         ones_d = '0;
      end else if (en_i) begin
         cnt_d  = cnt_q + 1'b1;
         ones_d = ones_q + (LEN_LOG2+1)'(bit_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         ones_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ones_q <= ones_d;
      end
   end

   assign ones_o = ones_q;
   assign wrap_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/sc_stream_sequencer.sv
// Job sequencer for a pair of stochastic number generators.
// Seeds, runs N cycles, counts combined ones, returns a scaled result.
module sc_stream_sequencer
   import sc_pkg::*;
#(
   parameter int unsigned LEN_LOG2 = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [SC_PROB_W-1:0] req_prob_a,
   input  logic [SC_PROB_W-1:0] req_prob_b,
   input  logic [1:0]           req_op,
   input  logic                 abort,
   output logic                 sng_rst,
   output logic [SC_PROB_W-1:0] sng_prob_a,
   output logic [SC_PROB_W-1:0] sng_prob_b,
   input  logic                 bit_a,
   input  logic                 bit_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [SC_PROB_W-1:0] rsp_result,
   output logic [LEN_LOG2:0]    rsp_ones
);

   localparam int unsigned SHIFT = LEN_LOG2 - 8;

   sc_seq_state_t        state_q, state_d;
   sc_op_t               op_q;
   logic [SC_PROB_W-1:0] prob_a_q, prob_b_q;
   logic                 rsp_valid_q;
   logic [SC_PROB_W-1:0] rsp_result_q;
   logic [LEN_LOG2:0]    rsp_ones_q;

   logic                 cnt_clr, cnt_en, wrap;
   logic [LEN_LOG2:0]    ones, ones_sh;
   logic [SC_PROB_W-1:0] scaled;

   sc_ones_counter #(.LEN_LOG2(LEN_LOG2)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .bit_i  (sc_combine(op_q, bit_a, bit_b)),
      .ones_o (ones),
      .wrap_o (wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SEQ_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: if (req_valid) state_d = SEQ_SEED;
         SEQ_SEED: state_d = abort ? SEQ_IDLE : SEQ_RUN;
         SEQ_RUN: begin
            if (abort)     state_d = SEQ_IDLE;
            else if (wrap) state_d = SEQ_DONE;
         end
         SEQ_DONE: begin
            if (abort || (rsp_valid_q && rsp_ready)) state_d = SEQ_IDLE;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == SEQ_IDLE);
      sng_rst   = (state_q == SEQ_SEED);
      cnt_en    = (state_q == SEQ_RUN) && !abort;
      cnt_clr   = (state_q != SEQ_RUN) || abort;
   end

   // Saturate so a run of all ones (ones == N) still fits 8 bits.
   assign ones_sh = ones >> SHIFT;
   assign scaled  = (ones_sh > (LEN_LOG2+1)'(255)) ? 8'hFF : ones_sh[7:0];

   // Results are captured one cycle into DONE, after the last sample lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= SC_OP_AND;
         prob_a_q     <= '0;
         prob_b_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_ones_q   <= '0;
      end else begin
         if (req_valid && req_ready) begin
            op_q     <= sc_op_t'(req_op);
            prob_a_q <= req_prob_a;
            prob_b_q <= req_prob_b;
         end
         if (state_q == SEQ_DONE) begin
            if (abort) begin
               rsp_valid_q <= 1'b0;
            end else if (!rsp_valid_q) begin
               rsp_valid_q  <= 1'b1;
               rsp_ones_q   <= ones;
               rsp_result_q <= scaled;
            end else if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
            end
         end
      end
   end

   assign sng_prob_a = prob_a_q;
   assign sng_prob_b = prob_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_ones   = rsp_ones_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Bench for sc_stream_sequencer: N=256 instance for most scenarios,
// N=1024 instance for the long-stream and mid-run reset scenario.
module tb_sc_stream_sequencer;

   typedef struct {
      int ones;
      int result;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [7:0] req_prob_a, req_prob_b;
   logic [1:0] req_op;
   logic       abort;
   logic       bit_a, bit_b;
   logic       rsp_ready;
   logic       ph = 1'b0;
   int         mode;

   logic       req_ready8, sng_rst8, rsp_valid8;
   logic [7:0] sng_prob_a8, sng_prob_b8, rsp_result8;
   logic [8:0] rsp_ones8;

   logic        req_ready10, sng_rst10, rsp_valid10;
   logic [7:0]  sng_prob_a10, sng_prob_b10, rsp_result10;
   logic [10:0] rsp_ones10;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(negedge clk) ph <= ~ph;

   assign bit_a = (mode == 0) | ((mode == 1) & ph);
   assign bit_b = (mode == 0) | (mode == 1) | ((mode == 2) & ph);

   sc_stream_sequencer #(.LEN_LOG2(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready8),
      .req_prob_a(req_prob_a), .req_prob_b(req_prob_b), .req_op(req_op),
      .abort(abort), .sng_rst(sng_rst8),
      .sng_prob_a(sng_prob_a8), .sng_prob_b(sng_prob_b8),
      .bit_a(bit_a), .bit_b(bit_b),
      .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result8), .rsp_ones(rsp_ones8)
   );

   sc_stream_sequencer #(.LEN_LOG2(10)) dut10 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready10),
      .req_prob_a(req_prob_a), .req_prob_b(req_prob_b), .req_op(req_op),
      .abort(abort), .sng_rst(sng_rst10),
      .sng_prob_a(sng_prob_a10), .sng_prob_b(sng_prob_b10),
      .bit_a(bit_a), .bit_b(bit_b),
      .rsp_valid(rsp_valid10), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result10), .rsp_ones(rsp_ones10)
   );

   function automatic int sat8(input int ones, input int sh);
      int v;
      v = ones >> sh;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic start_job(input logic [1:0] op, input logic [7:0] pa,
                            input logic [7:0] pb, input int exp_ones);
      int n;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = op;
      req_prob_a = pa;
      req_prob_b = pb;
      n = 0;
      while (!req_ready8 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (req_ready8 !== 1'b1) begin
         bad++;
         $display("FAIL accept: req_ready=%b want 1", req_ready8);
      end else begin
         e.ones = exp_ones;
         e.result = sat8(exp_ones, 0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int exp_lat);
      int lat;
      lat = 0;
      while (1) begin
         @(negedge clk);
         if (rsp_valid8 || lat > 3000) break;
         @(posedge clk);
         lat++;
      end
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL latency: got %0d want %0d", lat, exp_lat);
      end
   endtask

   task automatic take_rsp();
      exp_t e;
      total++;
      if (rsp_valid8 !== 1'b1) begin
         bad++;
         $display("FAIL rsp_valid: got %b want 1", rsp_valid8);
      end
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard: got empty want entry");
      end else begin
         e = sb.pop_front();
         total++;
         if (rsp_ones8 !== 9'(e.ones)) begin
            bad++;
            $display("FAIL rsp_ones: got %0d want %0d", rsp_ones8, e.ones);
         end
         total++;
         if (rsp_result8 !== 8'(e.result)) begin
            bad++;
            $display("FAIL rsp_result: got %0d want %0d", rsp_result8, e.result);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({rsp_valid8, req_ready8} !== 2'b01) begin
         bad++;
         $display("FAIL post_handshake: valid,ready=%b want 01",
                  {rsp_valid8, req_ready8});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_prob_a = 8'h00;
      req_prob_b = 8'h00;
      req_op = 2'b00;
      abort = 1'b0;
      rsp_ready = 1'b0;
      mode = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready8, sng_rst8, sng_prob_a8, sng_prob_b8, rsp_valid8,
           rsp_result8, rsp_ones8} !== {2'b10, 16'h0, 1'b0, 8'h0, 9'h0}) begin
         bad++;
         $display("FAIL reset8: got %h", {req_ready8, sng_rst8, sng_prob_a8,
                  sng_prob_b8, rsp_valid8, rsp_result8, rsp_ones8});
      end
      total++;
      if ({req_ready10, sng_rst10, rsp_valid10, rsp_ones10} !== {3'b100, 11'h0}) begin
         bad++;
         $display("FAIL reset10: got %h want %h",
                  {req_ready10, sng_rst10, rsp_valid10, rsp_ones10}, {3'b100, 11'h0});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_and_ones();
      mode = 0;
      start_job(2'b00, 8'hC3, 8'h5A, 256);
      wait_rsp(258);
      take_rsp();
      repeat (5) @(negedge clk);
      total++;
      if ({sng_prob_a8, sng_prob_b8} !== 16'hC35A) begin
         bad++;
         $display("FAIL prob_hold: got %h want c35a", {sng_prob_a8, sng_prob_b8});
      end
   endtask

   task automatic test_toggle();
      mode = 1;
      start_job(2'b00, 8'h80, 8'hFF, 128);
      wait_rsp(258);
      take_rsp();
      start_job(2'b10, 8'h80, 8'hFF, 128);
      wait_rsp(258);
      take_rsp();
   endtask

   task automatic test_or_pass();
      mode = 2;
      start_job(2'b01, 8'h00, 8'h80, 128);
      wait_rsp(258);
      take_rsp();
      start_job(2'b11, 8'h00, 8'h80, 0);
      wait_rsp(258);
      take_rsp();
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      exp_t e;
      mode = 0;
      start_job(2'b00, 8'h22, 8'h33, 256);
      wait_rsp(258);
      held = rsp_result8;
      req_valid = 1'b1;
      req_op = 2'b00;
      req_prob_a = 8'h11;
      req_prob_b = 8'h44;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({rsp_valid8, req_ready8, sng_rst8, rsp_result8, rsp_ones8} !==
             {3'b100, held, 9'd256}) begin
            bad++;
            $display("FAIL stall[%0d]: v,rdy,rst=%b res=%0d ones=%0d", i,
                     {rsp_valid8, req_ready8, sng_rst8}, rsp_result8, rsp_ones8);
         end
      end
      take_rsp();
      total++;
      if (sng_rst8 !== 1'b0) begin
         bad++;
         $display("FAIL early_accept: sng_rst=%b want 0", sng_rst8);
      end
      e.ones = 256;
      e.result = 255;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      total++;
      if ({sng_rst8, sng_prob_a8} !== {1'b1, 8'h11}) begin
         bad++;
         $display("FAIL second_accept: rst,prob=%h want 111", {sng_rst8, sng_prob_a8});
      end
      wait_rsp(258);
      take_rsp();
   endtask

   task automatic test_abort();
      logic saw;
      mode = 0;
      start_job(2'b00, 8'h01, 8'h02, 256);
      repeat (51) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      void'(sb.pop_back());
      total++;
      if ({req_ready8, rsp_valid8} !== 2'b10) begin
         bad++;
         $display("FAIL abort_run: ready,valid=%b want 10", {req_ready8, rsp_valid8});
      end
      saw = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid8) saw = 1'b1;
      end
      total++;
      if (saw !== 1'b0) begin
         bad++;
         $display("FAIL abort_norsp: rsp_valid seen=%b want 0", saw);
      end
      start_job(2'b00, 8'h01, 8'h02, 256);
      wait_rsp(258);
      take_rsp();
      start_job(2'b00, 8'h05, 8'h06, 256);
      wait_rsp(258);
      abort = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      rsp_ready = 1'b0;
      void'(sb.pop_back());
      total++;
      if ({req_ready8, rsp_valid8} !== 2'b10) begin
         bad++;
         $display("FAIL abort_done: ready,valid=%b want 10", {req_ready8, rsp_valid8});
      end
   endtask

   task automatic test_reset_len10();
      int lat;
      mode = 0;
      start_job(2'b00, 8'hA5, 8'h5A, 256);
      repeat (100) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      total++;
      if ({req_ready8, sng_rst8, sng_prob_a8, sng_prob_b8, rsp_valid8,
           rsp_result8, rsp_ones8} !== {2'b10, 16'h0, 1'b0, 8'h0, 9'h0}) begin
         bad++;
         $display("FAIL async_rst8: got %h", {req_ready8, sng_rst8, sng_prob_a8,
                  sng_prob_b8, rsp_valid8, rsp_result8, rsp_ones8});
      end
      total++;
      if ({req_ready10, sng_rst10, sng_prob_a10, sng_prob_b10, rsp_valid10,
           rsp_ones10} !== {2'b10, 16'h0, 1'b0, 11'h0}) begin
         bad++;
         $display("FAIL async_rst10: got %h", {req_ready10, sng_rst10,
                  sng_prob_a10, sng_prob_b10, rsp_valid10, rsp_ones10});
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_job(2'b00, 8'hFF, 8'hFF, 256);
      lat = 0;
      while (1) begin
         @(negedge clk);
         if (rsp_valid10 || lat > 3000) break;
         @(posedge clk);
         lat++;
      end
      total++;
      if (lat !== 1026) begin
         bad++;
         $display("FAIL latency10: got %0d want 1026", lat);
      end
      total++;
      if ({rsp_ones10, rsp_result10} !== {11'd1024, 8'd255}) begin
         bad++;
         $display("FAIL result10: ones=%0d res=%0d want 1024 255",
                  rsp_ones10, rsp_result10);
      end
      take_rsp();
      total++;
      if (rsp_valid10 !== 1'b0) begin
         bad++;
         $display("FAIL handshake10: rsp_valid=%b want 0", rsp_valid10);
      end
   endtask

   initial begin
      test_reset();
      test_and_ones();
      test_toggle();
      test_or_pass();
      test_backpressure();
      test_abort();
      test_reset_len10();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
